ps_pc_stack: RTL and testbench

//  Program-sequencer hardware stack. Executes the push/pop commands decoded alongside the bus-connect

---
 rtl/ps_pc_stack.sv | 116 +++++++++++
 tb/tb_ps_pc_stack.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps_pc_stack.sv
// Program-sequencer hardware stack holding return addresses and bus pushes.
// The top-of-stack word is registered and bypasses same-cycle write data.
module ps_pc_stack #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_pshstck,
  input  logic          ps_popstck,
  input  logic          ps_call,
  input  logic [DW-1:0] ps_pc_nxt,
  input  logic [DW-1:0] ps_stck_din,
  input  logic          ps_stck_clr_err,
  output logic [DW-1:0] ps_stck_dout,
  output logic [AW:0]   ps_stck_cnt,
  output logic          ps_stck_empty,
  output logic          ps_stck_full,
  output logic          ps_stck_ovf,
  output logic          ps_stck_unf
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          ovf_q, unf_q;
  logic          ovf_set, unf_set;

  logic          push, pop;
  logic [DW-1:0] push_data;
  logic          is_empty, is_full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  assign push      = ps_pshstck | ps_call;
  assign pop       = ps_popstck;
  assign push_data = ps_call ? ps_pc_nxt : ps_stck_din;
  assign is_empty  = (cnt_q == '0);
  assign is_full   = (cnt_q == CNT_FULL);

  // Entry that becomes the new top after a plain pop.
  assign rd_addr = AW'(cnt_q - CNT_TWO);
  assign rd_data = mem_q[rd_addr];

  always_comb begin
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_addr = cnt_q[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (push && pop) begin
      // Replace top; on an empty stack the pop is dropped and the push proceeds.
      wr_en  = 1'b1;
      dout_d = push_data;
      if (is_empty) begin
        cnt_d = CNT_ONE;
      end else begin
        wr_addr = AW'(cnt_q - CNT_ONE);
      end
    end else if (push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en  = 1'b1;
        cnt_d  = cnt_q + CNT_ONE;
        dout_d = push_data;
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_set = 1'b1;
      end else begin
        cnt_d  = cnt_q - CNT_ONE;
        dout_d = (cnt_q == CNT_ONE) ? '0 : rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      // A fresh error outranks a concurrent clear.
      ovf_q  <= ovf_set | (ovf_q & ~ps_stck_clr_err);
      unf_q  <= unf_set | (unf_q & ~ps_stck_clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= push_data;
    end
  end

  assign ps_stck_dout  = dout_q;
  assign ps_stck_cnt   = cnt_q;
  assign ps_stck_empty = is_empty;
  assign ps_stck_full  = is_full;
  assign ps_stck_ovf   = ovf_q;
  assign ps_stck_unf   = unf_q;

endmodule

// File: tb/tb_ps_pc_stack.sv
// Directed bench for ps_pc_stack: call/push/pop sequences, full/empty limits,
// sticky error clear priority, and reset dominance.
module tb_ps_pc_stack;

  logic        clk;
  logic        rst;
  logic        ps_pshstck;
  logic        ps_popstck;
  logic        ps_call;
  logic [15:0] ps_pc_nxt;
  logic [15:0] ps_stck_din;
  logic        ps_stck_clr_err;
  logic [15:0] ps_stck_dout;
  logic [4:0]  ps_stck_cnt;
  logic        ps_stck_empty;
  logic        ps_stck_full;
  logic        ps_stck_ovf;
  logic        ps_stck_unf;

  int n_assert = 0;
  int n_fail   = 0;

  ps_pc_stack #(.DW(16), .DEPTH(16), .AW(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps_pshstck     (ps_pshstck),
    .ps_popstck     (ps_popstck),
    .ps_call        (ps_call),
    .ps_pc_nxt      (ps_pc_nxt),
    .ps_stck_din    (ps_stck_din),
    .ps_stck_clr_err(ps_stck_clr_err),
    .ps_stck_dout   (ps_stck_dout),
    .ps_stck_cnt    (ps_stck_cnt),
    .ps_stck_empty  (ps_stck_empty),
    .ps_stck_full   (ps_stck_full),
    .ps_stck_ovf    (ps_stck_ovf),
    .ps_stck_unf    (ps_stck_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic psh, input logic pop, input logic call,
                       input logic [15:0] pc, input logic [15:0] din, input logic clr);
    ps_pshstck      = psh;
    ps_popstck      = pop;
    ps_call         = call;
    ps_pc_nxt       = pc;
    ps_stck_din     = din;
    ps_stck_clr_err = clr;
  endtask

  // One clock per transaction; outputs sampled 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    $display("[%0t] %s: cnt=%0d dout=%h empty=%b full=%b ovf=%b unf=%b",
             $time, tag, ps_stck_cnt, ps_stck_dout, ps_stck_empty,
             ps_stck_full, ps_stck_ovf, ps_stck_unf);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    // 1: reset state
    step("reset0");
    step("reset1");
    chk("rst_cnt",   ps_stck_cnt, 5'd0);
    chk("rst_empty", ps_stck_empty, 1'b1);
    chk("rst_full",  ps_stck_full, 1'b0);
    chk("rst_dout",  ps_stck_dout, 16'h0000);
    chk("rst_ovf",   ps_stck_ovf, 1'b0);
    chk("rst_unf",   ps_stck_unf, 1'b0);
    rst = 1'b0;

    // 2: call, push, two pops
    drive(1'b0, 1'b0, 1'b1, 16'h0123, 16'h0000, 1'b0);
    step("call");
    chk("call_dout", ps_stck_dout, 16'h0123);
    chk("call_cnt",  ps_stck_cnt, 5'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
    step("push");
    chk("push_dout", ps_stck_dout, 16'hBEEF);
    chk("push_cnt",  ps_stck_cnt, 5'd2);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("pop1");
    chk("pop1_dout", ps_stck_dout, 16'h0123);
    chk("pop1_cnt",  ps_stck_cnt, 5'd1);
    step("pop2");
    chk("pop2_dout",  ps_stck_dout, 16'h0000);
    chk("pop2_cnt",   ps_stck_cnt, 5'd0);
    chk("pop2_empty", ps_stck_empty, 1'b1);
    chk("pop2_unf",   ps_stck_unf, 1'b0);

    // 3: fill to full, overflow, clear priority
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'(i), 1'b0);
      step("fill");
      chk("fill_dout", ps_stck_dout, 32'(i));
    end
    chk("fill_cnt",  ps_stck_cnt, 5'd16);
    chk("fill_full", ps_stck_full, 1'b1);
    chk("fill_ovf",  ps_stck_ovf, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
    step("push17");
    chk("ovf_flag", ps_stck_ovf, 1'b1);
    chk("ovf_cnt",  ps_stck_cnt, 5'd16);
    chk("ovf_dout", ps_stck_dout, 16'h000F);
    chk("ovf_full", ps_stck_full, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
    step("ovf_clr_and_push");
    chk("ovf_set_wins", ps_stck_ovf, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step("ovf_clr");
    chk("ovf_cleared", ps_stck_ovf, 1'b0);
    chk("ovf_clr_cnt", ps_stck_cnt, 5'd16);
    // popping a full stack exposes entry 14
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("pop_full");
    chk("pop_full_dout", ps_stck_dout, 16'h000E);
    chk("pop_full_cnt",  ps_stck_cnt, 5'd15);

    // 4: underflow and clear priority
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("reset2");
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("pop_empty");
    chk("unf_flag", ps_stck_unf, 1'b1);
    chk("unf_cnt",  ps_stck_cnt, 5'd0);
    chk("unf_dout", ps_stck_dout, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step("unf_clr_and_pop");
    chk("unf_set_wins", ps_stck_unf, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step("unf_clr");
    chk("unf_cleared", ps_stck_unf, 1'b0);

    // push+pop on empty: push executes, no error
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0055, 1'b0);
    step("pushpop_empty");
    chk("pp_empty_cnt",  ps_stck_cnt, 5'd1);
    chk("pp_empty_dout", ps_stck_dout, 16'h0055);
    chk("pp_empty_unf",  ps_stck_unf, 1'b0);

    // 5: replace top at cnt=3
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("reset3");
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'(i), 1'b0);
      step("push_n");
    end
    chk("three_cnt",  ps_stck_cnt, 5'd3);
    chk("three_dout", ps_stck_dout, 16'h0003);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h00AA, 1'b0);
    step("replace");
    chk("repl_cnt",  ps_stck_cnt, 5'd3);
    chk("repl_dout", ps_stck_dout, 16'h00AA);
    chk("repl_ovf",  ps_stck_ovf, 1'b0);
    chk("repl_unf",  ps_stck_unf, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("pop_after_repl");
    chk("repl_pop_dout", ps_stck_dout, 16'h0002);
    chk("repl_pop_cnt",  ps_stck_cnt, 5'd2);
    step("pop_again");
    chk("repl_pop2_dout", ps_stck_dout, 16'h0001);

    // call takes priority over din when both push sources are active
    drive(1'b1, 1'b0, 1'b1, 16'h0777, 16'h0999, 1'b0);
    step("call_and_push");
    chk("call_sel_dout", ps_stck_dout, 16'h0777);
    chk("call_sel_cnt",  ps_stck_cnt, 5'd2);

    // 6: reset dominates a push at cnt=5
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("reset4");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'(16'h0010 + i), 1'b0);
      step("push_five");
    end
    chk("five_cnt", ps_stck_cnt, 5'd5);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0033, 1'b0);
    step("rst_with_push");
    chk("rstpush_cnt",  ps_stck_cnt, 5'd0);
    chk("rstpush_dout", ps_stck_dout, 16'h0000);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0042, 1'b0);
    step("push_after_rst");
    chk("after_rst_dout", ps_stck_dout, 16'h0042);
    chk("after_rst_cnt",  ps_stck_cnt, 5'd1);

    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step("idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
